// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, instruction field positions and sequencer states
package alu_pkg;
    localparam int N = 16;
    localparam logic [3:0] OP_ZERO   = 4'h0;
    localparam logic [3:0] OP_LOAD_A = 4'h1;
    localparam logic [3:0] OP_LOAD_B = 4'h3;
    localparam logic [3:0] OP_SHIFT  = 4'h8;
    localparam logic [3:0] OP_ADD    = 4'h9;
    localparam logic [3:0] OP_CMP    = 4'hA;
    localparam logic [3:0] OP_NEG    = 4'hB;
    localparam logic [3:0] OP_AND    = 4'hC;
    localparam logic [3:0] OP_OR     = 4'hD;
    localparam logic [3:0] OP_XOR    = 4'hE;
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LDI    = 4'h2;
    localparam logic [3:0] OP_HALT   = 4'hF;
    localparam int F_OPC  = 12;
    localparam int F_DST  = 9;
    localparam int F_SRCA = 6;
    localparam int F_SRCB = 3;
    typedef enum logic [2:0] {FETCH, IMM, EXEC, WB, HALTED} state_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: opcode classification for the sequencer
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_ldi,
    output logic       is_nop,
    output logic       is_halt,
    output logic       is_illegal,
    output logic       is_cmp
);
    assign is_alu     = opcode inside {OP_LOAD_A, OP_LOAD_B, OP_SHIFT, OP_ADD, OP_CMP,
                                       OP_NEG, OP_AND, OP_OR, OP_XOR};
    assign is_ldi     = opcode == OP_LDI;
    assign is_nop     = opcode == OP_NOP;
    assign is_halt    = opcode == OP_HALT;
    assign is_illegal = opcode inside {[4'h4:4'h7]};
    assign is_cmp     = opcode == OP_CMP;
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: FETCH/IMM/EXEC/WB sequencer issuing aluop, register selects and write-back
module alu_ctrl
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    input  logic [15:0]  instr_data,
    output logic         instr_ready,
    input  logic [N-1:0] alu_y,
    output logic [3:0]   aluop,
    output logic [2:0]   sel_a,
    output logic [2:0]   sel_b,
    output logic         b_imm,
    output logic [N-1:0] imm,
    output logic         wr_en,
    output logic [2:0]   wr_sel,
    output logic         flag_eq,
    output logic         flag_lt,
    output logic         halted,
    output logic         illegal,
    output logic [15:0]  retired
);
    state_t     state;
    logic [2:0] dst, src_a, src_b;
    logic       cmp;
    logic       is_alu, is_ldi, is_nop, is_halt, is_illegal, is_cmp;
    logic       unused_bits;

    assign unused_bits = ^{instr_data[2:0], alu_y[N-3:0]};
    assign instr_ready = !reset && (state == FETCH || state == IMM);

    alu_ctrl_decode u_dec (
        .opcode     (instr_data[F_OPC+:4]),
        .is_alu     (is_alu),
        .is_ldi     (is_ldi),
        .is_nop     (is_nop),
        .is_halt    (is_halt),
        .is_illegal (is_illegal),
        .is_cmp     (is_cmp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            aluop   <= OP_ZERO;
            sel_a   <= '0;
            sel_b   <= '0;
            b_imm   <= 1'b0;
            imm     <= '0;
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            flag_eq <= 1'b0;
            flag_lt <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
            dst     <= '0;
            src_a   <= '0;
            src_b   <= '0;
            cmp     <= 1'b0;
        end else begin
            case (state)
                FETCH: if (instr_valid) begin
                    dst     <= instr_data[F_DST+:3];
                    src_a   <= instr_data[F_SRCA+:3];
                    src_b   <= instr_data[F_SRCB+:3];
                    cmp     <= is_cmp;
                    illegal <= illegal | is_illegal;
                    if (is_nop || is_halt) retired <= retired + 16'd1;
                    if (is_halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                    if (is_ldi) state <= IMM;
                    if (is_alu) begin
                        state <= EXEC;
                        aluop <= instr_data[F_OPC+:4];
                        sel_a <= instr_data[F_SRCA+:3];
                        sel_b <= instr_data[F_SRCB+:3];
                    end
                end
                IMM: if (instr_valid) begin
                    imm   <= instr_data;
                    state <= EXEC;
                    aluop <= OP_LOAD_B;
                    sel_a <= src_a;
                    sel_b <= src_b;
                    b_imm <= 1'b1;
                end
                EXEC: begin
                    state  <= WB;
                    wr_en  <= !cmp;
                    wr_sel <= cmp ? 3'd0 : dst;
                end
                WB: begin
                    state   <= FETCH;
                    wr_en   <= 1'b0;
                    wr_sel  <= '0;
                    aluop   <= OP_ZERO;
                    sel_a   <= '0;
                    sel_b   <= '0;
                    b_imm   <= 1'b0;
                    retired <= retired + 16'd1;
                    if (cmp) begin
                        flag_eq <= alu_y[N-1];
                        flag_lt <= alu_y[N-2];
                    end
                end
                HALTED: ;
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed table, corner sequences and randomized stream against a queue model
module tb_alu_ctrl;
    import alu_pkg::*;

    logic         clk = 1'b0, reset = 1'b1, instr_valid = 1'b0;
    logic [15:0]  instr_data = '0, alu_y = '0;
    logic         instr_ready, b_imm, wr_en, flag_eq, flag_lt, halted, illegal;
    logic [3:0]   aluop;
    logic [2:0]   sel_a, sel_b, wr_sel;
    logic [15:0]  imm, retired;

    alu_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_ready(instr_ready), .alu_y(alu_y), .aluop(aluop), .sel_a(sel_a),
        .sel_b(sel_b), .b_imm(b_imm), .imm(imm), .wr_en(wr_en), .wr_sel(wr_sel),
        .flag_eq(flag_eq), .flag_lt(flag_lt), .halted(halted), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] w0, w1, y;
        logic [3:0]  op;
        logic [2:0]  sa, sb;
        logic        bi, wr;
        logic [2:0]  ws;
        logic [15:0] im;
        logic        ret, ill, eq, lt;
    } vec_t;

    typedef struct {
        logic [2:0]  ws;
        logic [3:0]  op;
        logic [2:0]  sa, sb;
        logic        bi;
        logic [15:0] im;
    } wr_t;

    wr_t  expq[$];
    wr_t  mon_e;
    bit   mon_on = 1'b0;
    logic prev_wr = 1'b0;

    always @(negedge clk) begin
        if (wr_en) begin
            chk("wr_en_back_to_back", {31'd0, prev_wr}, 0);
            if (mon_on) begin
                if (expq.size() == 0) chk("rnd_unexpected_write", 1, 0);
                else begin
                    mon_e = expq.pop_front();
                    chk("rnd_wr_sel", {29'd0, wr_sel}, {29'd0, mon_e.ws});
                    chk("rnd_aluop", {28'd0, aluop}, {28'd0, mon_e.op});
                    chk("rnd_sel_a", {29'd0, sel_a}, {29'd0, mon_e.sa});
                    chk("rnd_sel_b", {29'd0, sel_b}, {29'd0, mon_e.sb});
                    chk("rnd_b_imm", {31'd0, b_imm}, {31'd0, mon_e.bi});
                    chk("rnd_imm", {16'd0, imm}, {16'd0, mon_e.im});
                end
            end
        end
        prev_wr = wr_en;
    end

    task automatic send(input logic [15:0] w, input logic [15:0] y);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 1, 0);
        alu_y = y;
        instr_valid = 1'b1;
        instr_data = w;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_data = 16'($urandom);
    endtask

    vec_t        v[10];
    logic [15:0] er, mret, mimm, w, iw, y;
    logic        mill, meq, mlt;
    logic [3:0]  op;

    initial begin
        v[0] = '{16'h9450, 16'h0000, 16'h0000, 4'h9, 3'd1, 3'd2, 1'b0, 1'b1, 3'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        v[1] = '{16'h2E00, 16'h1234, 16'h0000, 4'h3, 3'd0, 3'd0, 1'b1, 1'b1, 3'd7, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0};
        v[2] = '{16'hA0C8, 16'h0000, 16'h4000, 4'hA, 3'd3, 3'd1, 1'b0, 1'b0, 3'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1};
        v[3] = '{16'h5000, 16'h0000, 16'h0000, 4'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1};
        v[4] = '{16'h9450, 16'h0000, 16'hFFFF, 4'h9, 3'd1, 3'd2, 1'b0, 1'b1, 3'd2, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1};
        v[5] = '{16'hA000, 16'h0000, 16'h8000, 4'hA, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0};
        v[6] = '{16'hE3F8, 16'h0000, 16'h0000, 4'hE, 3'd7, 3'd7, 1'b0, 1'b1, 3'd1, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0};
        v[7] = '{16'h0000, 16'h0000, 16'h0000, 4'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0};
        v[8] = '{16'h1A40, 16'h0000, 16'h0000, 4'h1, 3'd1, 3'd0, 1'b0, 1'b1, 3'd5, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0};
        v[9] = '{16'h2A7F, 16'hBEEF, 16'h0000, 4'h3, 3'd1, 3'd7, 1'b1, 1'b1, 3'd5, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0};

        #12;
        chk("rst_ready", {31'd0, instr_ready}, 0);
        chk("rst_aluop", {28'd0, aluop}, 0);
        chk("rst_retired", {16'd0, retired}, 0);
        chk("rst_outs", {16'd0, imm, wr_en, b_imm, halted, illegal, flag_eq, flag_lt, sel_a, sel_b, wr_sel}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_ready", {31'd0, instr_ready}, 1);

        er = '0;
        for (int i = 0; i < 10; i++) begin
            send(v[i].w0, v[i].y);
            w = v[i].w0;
            if (w[15:12] == OP_LDI) send(v[i].w1, v[i].y);
            if (v[i].op != 4'h0) begin
                chk($sformatf("v%0d_exec_aluop", i), {28'd0, aluop}, {28'd0, v[i].op});
                chk($sformatf("v%0d_exec_sel_a", i), {29'd0, sel_a}, {29'd0, v[i].sa});
                chk($sformatf("v%0d_exec_sel_b", i), {29'd0, sel_b}, {29'd0, v[i].sb});
                chk($sformatf("v%0d_exec_b_imm", i), {31'd0, b_imm}, {31'd0, v[i].bi});
                chk($sformatf("v%0d_exec_wr_en", i), {31'd0, wr_en}, 0);
                chk($sformatf("v%0d_exec_ready", i), {31'd0, instr_ready}, 0);
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_wb_aluop", i), {28'd0, aluop}, {28'd0, v[i].op});
                chk($sformatf("v%0d_wb_wr_en", i), {31'd0, wr_en}, {31'd0, v[i].wr});
                if (v[i].wr) chk($sformatf("v%0d_wb_wr_sel", i), {29'd0, wr_sel}, {29'd0, v[i].ws});
                chk($sformatf("v%0d_wb_ready", i), {31'd0, instr_ready}, 0);
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_fetch_aluop", i), {28'd0, aluop}, 0);
                chk($sformatf("v%0d_fetch_sels", i), {25'd0, sel_a, sel_b, b_imm}, 0);
                chk($sformatf("v%0d_fetch_wr_en", i), {31'd0, wr_en}, 0);
                chk($sformatf("v%0d_fetch_ready", i), {31'd0, instr_ready}, 1);
            end else
                chk($sformatf("v%0d_aluop_idle", i), {28'd0, aluop}, 0);
            er = er + {15'd0, v[i].ret};
            chk($sformatf("v%0d_retired", i), {16'd0, retired}, {16'd0, er});
            chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, v[i].ill});
            chk($sformatf("v%0d_flags", i), {30'd0, flag_eq, flag_lt}, {30'd0, v[i].eq, v[i].lt});
            chk($sformatf("v%0d_imm", i), {16'd0, imm}, {16'd0, v[i].im});
        end

        @(negedge clk);
        instr_valid = 1'b1;
        instr_data = 16'hF000;
        @(posedge clk);
        #1;
        instr_data = 16'h9450;
        chk("halt_halted", {31'd0, halted}, 1);
        chk("halt_retired", {16'd0, retired}, {16'd0, er + 16'd1});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_ready_low", {31'd0, instr_ready}, 0);
            chk("halt_stays", {31'd0, halted}, 1);
        end
        chk("halt_no_write", {31'd0, wr_en}, 0);
        reset = 1'b1;
        #1;
        chk("halt_rst_halted", {31'd0, halted}, 0);
        chk("halt_rst_ready", {31'd0, instr_ready}, 0);
        chk("halt_rst_state", {16'd0, retired, illegal, flag_eq, flag_lt}, 0);
        chk("halt_rst_imm", {16'd0, imm}, 0);
        @(negedge clk);
        reset = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("halt_rel_ready", {31'd0, instr_ready}, 1);

        send(16'h9450, 16'h0);
        @(posedge clk);
        #1;
        chk("midwb_wr_en", {31'd0, wr_en}, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midwb_async_wr_en", {31'd0, wr_en}, 0);
        chk("midwb_async_aluop", {28'd0, aluop}, 0);
        chk("midwb_ready", {31'd0, instr_ready}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midwb_no_retire", {16'd0, retired}, 0);
        chk("midwb_no_write", {31'd0, wr_en}, 0);
        chk("midwb_fetch", {31'd0, instr_ready}, 1);

        mon_on = 1'b1;
        mret = '0; mimm = '0; mill = 1'b0; meq = 1'b0; mlt = 1'b0;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 14));
            w = {op, 12'($urandom)};
            y = 16'($urandom);
            send(w, y);
            if (op == 4'h0) mret++;
            else if (op >= 4'h4 && op <= 4'h7) mill = 1'b1;
            else if (op == 4'h2) begin
                iw = 16'($urandom);
                send(iw, y);
                mimm = iw;
                expq.push_back('{w[11:9], 4'h3, w[8:6], w[5:3], 1'b1, mimm});
                mret++;
            end else begin
                if (op == 4'hA) begin
                    meq = y[15];
                    mlt = y[14];
                end else
                    expq.push_back('{w[11:9], op, w[8:6], w[5:3], 1'b0, mimm});
                mret++;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        mon_on = 1'b0;
        chk("rnd_retired", {16'd0, retired}, {16'd0, mret});
        chk("rnd_illegal", {31'd0, illegal}, {31'd0, mill});
        chk("rnd_flags", {30'd0, flag_eq, flag_lt}, {30'd0, meq, mlt});
        chk("rnd_imm_final", {16'd0, imm}, {16'd0, mimm});
        chk("rnd_pending_writes", expq.size(), 0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        instr_valid = 1'b1;
        instr_data = 16'h0000;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_ffff", {16'd0, retired}, 32'h0000FFFF);
        @(posedge clk);
        #1;
        chk("wrap_zero", {16'd0, retired}, 0);
        instr_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Multi-cycle control sequencer that drives the 16-bit `ALU` from a stream of instruction words.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Presents `aluop` and register-file read selects to the datapath, then issues a one-cycle register write-back.
- Sits between the instruction source (ROM/fetch) and the register-file + ALU datapath; it is the issuing side of the `aluop` interface.

## Interface
- `N`, 16, datapath width; fixed at 16 (`alu_y[15:14]` flag positions depend on it).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `instr_valid`  in  1  instruction word present on `instr_data`.
- `instr_data`  in  16  instruction word.
- `instr_ready`  out  1  sequencer accepts a word this cycle.
- `alu_y`  in  N  ALU result, fed back for flag capture.
- `aluop`  out  4  operation code to ALU.
- `sel_a`  out  3  register-file read select for ALU A.
- `sel_b`  out  3  register-file read select for ALU B.
- `b_imm`  out  1  datapath muxes `imm` onto ALU B instead of register `sel_b`.
- `imm`  out  N  immediate operand.
- `wr_en`  out  1  one-cycle register-file write strobe (data = ALU Y).
- `wr_sel`  out  3  destination register.
- `flag_eq`, `flag_lt`  out  1 each  flags latched from the last CMP.
- `halted`  out  1  HALT executed.
- `illegal`  out  1  sticky: undefined opcode seen.
- `retired`  out  16  count of completed instructions; wraps 0xFFFF -> 0x0000.

## Operation
Instruction format:
- `[15:12]` opcode.
- `[11:9]` dest.
- `[8:6]` srcA.
- `[5:3]` srcB.
- `[2:0]` ignored.

Opcodes:
- ALU ops use the ALU codes directly: 0x1 LOAD_A, 0x3 LOAD_B, 0x8 SHIFT, 0x9 ADD, 0xA CMP, 0xB NEG, 0xC AND, 0xD OR, 0xE XOR.
- 0x0 NOP.
- 0x2 LDI (two-word): next accepted word is `imm`; executes as LOAD_B with `b_imm=1`, dest from the first word.
- 0xF HALT.
- 0x4–0x7 illegal.

States:
- FETCH:
  - `instr_ready=1`. On `instr_valid & instr_ready`, latch the word.
  - NOP: stays in FETCH, `retired`+1.
  - HALT: go to HALTED, `retired`+1.
  - Illegal opcode: set `illegal`, treat as NOP (no `retired` increment).
  - LDI: go to IMM.
  - Otherwise: go to EXEC.
- IMM: `instr_ready=1`. On handshake, latch `imm`, go to EXEC.
- EXEC: drive `aluop`, `sel_a`, `sel_b`, `b_imm`; `instr_ready=0`. Next state is WB.
- WB:
  - Hold the EXEC outputs.
  - Non-CMP: `wr_en=1`, `wr_sel=dest`.
  - CMP: `wr_en=0`; latch `flag_eq<=alu_y[15]`, `flag_lt<=alu_y[14]`.
  - `retired`+1, then go to FETCH.
- HALTED: `instr_ready=0`, `halted=1`; only `reset` exits.

Rules:
- `aluop` is 0x0 (ALU outputs 0) in FETCH, IMM and HALTED.
- `sel_a`, `sel_b`, `b_imm` are 0 outside EXEC/WB.
- `wr_en` asserts in WB only, never two consecutive cycles.
- `imm` holds its last value until the next LDI.
- `instr_valid` deasserted in FETCH/IMM: the state waits indefinitely with no output changes.
- `instr_data` is ignored when not handshaking.

Reset values (asserted at any time, including mid-EXEC/WB):
- Immediate return to FETCH; no write completes.
- All outputs 0 except `instr_ready`.
- `instr_ready` is 0 while `reset` is high and 1 on the first cycle after release.
- `flags`, `illegal`, `retired`, `imm` cleared.

## Timing
- Handshake at edge T: EXEC during cycle T+1, WB during T+2 (write at edge T+3), `instr_ready` high again in cycle T+3.
- ALU instruction throughput: 1 per 3 cycles. LDI: 4 cycles with a back-to-back immediate word. NOP/illegal: 1 cycle.
- `flag_*` update at the WB-ending edge, visible from T+3.
- All outputs are registered except `instr_ready`, which is decoded from state (FETCH/IMM) and `reset`.

## Structure
- Shared package `alu_pkg` holds:
  - `OP_*` aluop constants (same values as `ALU`).
  - Opcodes `OP_NOP=0`, `OP_LDI=2`, `OP_HALT=F`.
  - Instruction field positions.
  - The state enum {FETCH, IMM, EXEC, WB, HALTED}.
- One natural sub-module: `alu_ctrl_decode` (combinational) — opcode -> {is_alu, is_ldi, is_nop, is_halt, is_illegal, is_cmp}.

## Test plan
- ADD 0x9_2_1_2 (`instr_data`=0x9450: dest r2, srcA r1, srcB r2) accepted at T -> `aluop`=0x9, `sel_a`=1, `sel_b`=2 in T+1..T+2; `wr_en`=1, `wr_sel`=2 only in T+2; `retired`=1.
- LDI 0x2E00 then 0x1234 -> `imm`=0x1234, `b_imm`=1, `aluop`=0x3, `wr_sel`=7; `instr_ready` low for 2 cycles after the second word.
- CMP with `alu_y`=0x4000 in WB -> `flag_eq`=0, `flag_lt`=1, `wr_en` never high.
- Opcode 0x5 -> `illegal`=1, no `wr_en`, `retired` unchanged. Next ADD executes normally.
- HALT 0xF000 -> `halted`=1, `instr_ready`=0 with `instr_valid` held high for 10 cycles; `reset` pulse -> `halted`=0.
- `reset` asserted mid-WB -> `wr_en` drops asynchronously. 65536 NOPs -> `retired` wraps to 0x0000.
